// File: rtl/sub_16_pipe_pkg.sv
// Shared width constants for the pipelined 16-bit add/subtract pair.
// Both datapaths split operands into two equal half-slices.
package sub_16_pipe_pkg;

  localparam int SIZE    = 16;
  localparam int HALF    = SIZE / 2;
  localparam int LATENCY = 3;

endpackage

// File: rtl/sub_16_pipe_if.sv
// Operand/result bundle for sub_16_pipe.
// master drives operands, slave returns the registered result.
interface sub_16_pipe_if
  import sub_16_pipe_pkg::*;
#(
  parameter int size = SIZE
);

  logic [size-1:0] a;
  logic [size-1:0] b;
  logic            b_in;
  logic            v_in;
  logic [size-1:0] diff;
  logic            b_out;
  logic            v_out;

  modport master (
    output a, b, b_in, v_in,
    input  diff, b_out, v_out
  );

  modport slave (
    input  a, b, b_in, v_in,
    output diff, b_out, v_out
  );

endinterface

// File: rtl/sub_16_pipe_half_sub.sv
// Combinational w-bit subtract slice with borrow in/out.
// The top bit of the zero-extended result is the borrow.
module half_sub #(
  parameter int w = 8
) (
  input  logic [w-1:0] x,
  input  logic [w-1:0] y,
  input  logic         bi,
  output logic [w-1:0] d,
  output logic         bo
);

  logic [w:0] r;

  assign r  = {1'b0, x} - {1'b0, y} - {{w{1'b0}}, bi};
  assign d  = r[w-1:0];
  assign bo = r[w];

endmodule

// File: rtl/sub_16_pipe.sv
// Three-stage unsigned subtractor: diff = a - b - b_in, borrow b_out.
// Low half resolves in stage 2, its borrow feeds the high half in stage 3.
module sub_16_pipe
  import sub_16_pipe_pkg::*;
#(
  parameter int size = SIZE
) (
  input logic          clock,
  input logic          reset,
  sub_16_pipe_if.slave bus
);

  localparam int half = size / 2;

  typedef struct packed {
    logic [half-1:0] a_lo;
    logic [half-1:0] a_hi;
    logic [half-1:0] b_lo;
    logic [half-1:0] b_hi;
    logic            b_in;
    logic            v;
  } ir_t;

  typedef struct packed {
    logic [half-1:0] a_hi;
    logic [half-1:0] b_hi;
    logic [half-1:0] d_lo;
    logic            brw;
    logic            v;
  } pr_t;

  ir_t             ir;
  pr_t             pr;
  logic [size-1:0] diff_q;
  logic            b_out_q;
  logic            v_q;

  logic [half-1:0] d_lo;
  logic [half-1:0] d_hi;
  logic            brw_mid;
  logic            brw_hi;

  half_sub #(.w(half)) u_lo (
    .x  (ir.a_lo),
    .y  (ir.b_lo),
    .bi (ir.b_in),
    .d  (d_lo),
    .bo (brw_mid)
  );

  half_sub #(.w(half)) u_hi (
    .x  (pr.a_hi),
    .y  (pr.b_hi),
    .bi (pr.brw),
    .d  (d_hi),
    .bo (brw_hi)
  );

  // Data advances every clock; only the valid bit qualifies a slot.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ir      <= '0;
      pr      <= '0;
      diff_q  <= '0;
      b_out_q <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      ir.a_lo <= bus.a[half-1:0];
      ir.a_hi <= bus.a[size-1:half];
      ir.b_lo <= bus.b[half-1:0];
      ir.b_hi <= bus.b[size-1:half];
      ir.b_in <= bus.b_in;
      ir.v    <= bus.v_in;

      pr.a_hi <= ir.a_hi;
      pr.b_hi <= ir.b_hi;
      pr.d_lo <= d_lo;
      pr.brw  <= brw_mid;
      pr.v    <= ir.v;

      diff_q  <= {d_hi, pr.d_lo};
      b_out_q <= brw_hi;
      v_q     <= pr.v;
    end
  end

  assign bus.diff  = diff_q;
  assign bus.b_out = b_out_q;
  assign bus.v_out = v_q;

endmodule

// File: tb/tb_sub_16_pipe.sv
// Directed bench for sub_16_pipe: reset, borrow cases,
// a holed stream and asynchronous reset with ops in flight.
module tb_sub_16_pipe;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  sub_16_pipe_if bus ();

  sub_16_pipe dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic drive(
    input logic [15:0] a,
    input logic [15:0] b,
    input logic        bin,
    input logic        v
  );
    @(negedge clock);
    bus.a    = a;
    bus.b    = b;
    bus.b_in = bin;
    bus.v_in = v;
  endtask

  task automatic idle();
    drive(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Launch one valid op and return just after its third edge.
  task automatic launch(
    input logic [15:0] a,
    input logic [15:0] b,
    input logic        bin
  );
    drive(a, b, bin, 1'b1);
    tick();
    idle();
    tick();
    idle();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(16'($urandom), 16'($urandom),
            1'($urandom), 1'($urandom));
      tick();
      checks++;
      if (bus.diff !== 16'h0 || bus.b_out !== 1'b0
          || bus.v_out !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: diff=%h b_out=%b v_out=%b want 0",
                 bus.diff, bus.b_out, bus.v_out);
      end
    end
    idle();
    #2 reset = 1'b1;
    drive(16'h0005, 16'h0003, 1'b0, 1'b1);
    for (int e = 1; e <= 3; e++) begin
      tick();
      if (e < 3) begin
        checks++;
        if (bus.v_out !== 1'b0) begin
          errors++;
          $display("FAIL reset_release_e%0d: v_out=%b want 0",
                   e, bus.v_out);
        end
      end
      idle();
    end
    checks++;
    if (bus.diff !== 16'h0002 || bus.b_out !== 1'b0
        || bus.v_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_op: diff=%h b_out=%b v=%b want 0002 0 1",
               bus.diff, bus.b_out, bus.v_out);
    end
  endtask

  task automatic test_basic();
    launch(16'h1234, 16'h0234, 1'b0);
    checks++;
    if (bus.diff !== 16'h1000 || bus.b_out !== 1'b0
        || bus.v_out !== 1'b1) begin
      errors++;
      $display("FAIL basic: diff=%h b_out=%b v=%b want 1000 0 1",
               bus.diff, bus.b_out, bus.v_out);
    end
    tick();
    checks++;
    if (bus.v_out !== 1'b0) begin
      errors++;
      $display("FAIL basic_one_cycle: v_out=%b want 0", bus.v_out);
    end
  endtask

  task automatic test_borrow_cross();
    launch(16'h0100, 16'h0001, 1'b0);
    checks++;
    if (bus.diff !== 16'h00FF || bus.b_out !== 1'b0
        || bus.v_out !== 1'b1) begin
      errors++;
      $display("FAIL cross_half: diff=%h b_out=%b v=%b want 00ff 0 1",
               bus.diff, bus.b_out, bus.v_out);
    end
    launch(16'h0000, 16'h0001, 1'b0);
    checks++;
    if (bus.diff !== 16'hFFFF || bus.b_out !== 1'b1) begin
      errors++;
      $display("FAIL wrap_zero: diff=%h b_out=%b want ffff 1",
               bus.diff, bus.b_out);
    end
    launch(16'h00FF, 16'h0100, 1'b0);
    checks++;
    if (bus.diff !== 16'hFFFF || bus.b_out !== 1'b1) begin
      errors++;
      $display("FAIL hi_borrow: diff=%h b_out=%b want ffff 1",
               bus.diff, bus.b_out);
    end
    launch(16'hFFFF, 16'h0000, 1'b1);
    checks++;
    if (bus.diff !== 16'hFFFE || bus.b_out !== 1'b0) begin
      errors++;
      $display("FAIL max_bin: diff=%h b_out=%b want fffe 0",
               bus.diff, bus.b_out);
    end
  endtask

  task automatic test_equal_bin();
    launch(16'h8000, 16'h8000, 1'b1);
    checks++;
    if (bus.diff !== 16'hFFFF || bus.b_out !== 1'b1) begin
      errors++;
      $display("FAIL equal_bin1: diff=%h b_out=%b want ffff 1",
               bus.diff, bus.b_out);
    end
    launch(16'h8000, 16'h8000, 1'b0);
    checks++;
    if (bus.diff !== 16'h0000 || bus.b_out !== 1'b0) begin
      errors++;
      $display("FAIL equal_bin0: diff=%h b_out=%b want 0000 0",
               bus.diff, bus.b_out);
    end
    launch(16'h0001, 16'h0000, 1'b1);
    checks++;
    if (bus.diff !== 16'h0000 || bus.b_out !== 1'b0) begin
      errors++;
      $display("FAIL lo_bin: diff=%h b_out=%b want 0000 0",
               bus.diff, bus.b_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ea [0:21];
    logic [15:0] eb [0:21];
    logic        ec [0:21];
    logic        ev [0:21];
    logic [16:0] r;
    for (int i = 0; i < 22; i++) begin
      ea[i] = 16'($urandom);
      eb[i] = 16'($urandom);
      ec[i] = 1'($urandom);
      ev[i] = (i < 20) && (i % 4 != 3);
      drive(ea[i], eb[i], ec[i], ev[i]);
      tick();
      if (i >= 2) begin
        r = {1'b0, ea[i-2]} - {1'b0, eb[i-2]} - 17'(ec[i-2]);
        checks++;
        if (bus.v_out !== ev[i-2]) begin
          errors++;
          $display("FAIL stream_v[%0d]: v_out=%b want %b",
                   i - 2, bus.v_out, ev[i-2]);
        end
        if (ev[i-2]) begin
          checks++;
          if (bus.diff !== r[15:0] || bus.b_out !== r[16]) begin
            errors++;
            $display("FAIL stream[%0d]: diff=%h b_out=%b want %h %b",
                     i - 2, bus.diff, bus.b_out, r[15:0], r[16]);
          end
        end
      end
    end
  endtask

  task automatic test_async_reset();
    drive(16'h0009, 16'h0001, 1'b0, 1'b1);
    tick();
    drive(16'h0100, 16'h0001, 1'b0, 1'b1);
    tick();
    drive(16'h0000, 16'h0001, 1'b0, 1'b1);
    tick();
    checks++;
    if (bus.v_out !== 1'b1 || bus.diff !== 16'h0008) begin
      errors++;
      $display("FAIL flight_pre: diff=%h v=%b want 0008 1",
               bus.diff, bus.v_out);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus.diff !== 16'h0 || bus.b_out !== 1'b0
        || bus.v_out !== 1'b0) begin
      errors++;
      $display("FAIL async_drop: diff=%h b_out=%b v=%b want 0",
               bus.diff, bus.b_out, bus.v_out);
    end
    idle();
    tick();
    idle();
    #2 reset = 1'b1;
    for (int e = 0; e < 4; e++) begin
      tick();
      checks++;
      if (bus.v_out !== 1'b0) begin
        errors++;
        $display("FAIL flight_ghost_e%0d: v_out=%b want 0",
                 e, bus.v_out);
      end
      idle();
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b0;
    bus.a    = '0;
    bus.b    = '0;
    bus.b_in = 1'b0;
    bus.v_in = 1'b0;
    test_reset();
    test_basic();
    test_borrow_cross();
    test_equal_bin();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/sub_16_pipe.md
Name: sub_16_pipe

Overview:
Pipelined unsigned subtractor: diff = a - b - b_in, with borrow-out b_out. It is the inverse datapath companion of the pipelined 16-bit adder in the Chapter 9 arithmetic set.
- Operands are split into low and high halves.
- The low half is resolved in the pipeline stage; its borrow ripples into the high half in the output stage.
- One result per clock; fixed latency.
- A valid bit travels alongside the data so downstream logic can qualify results.

Parameters:
size, 16, operand/result width; must be even and >= 4
half, size/2, width of each half-slice (derived; do not override independently)

Ports:
clock  input  1  rising-edge clock for all registers
reset  input  1  asynchronous, active-low; clears all pipeline registers
a  input  size  minuend, unsigned
b  input  size  subtrahend, unsigned
b_in  input  1  borrow-in (subtract one extra)
v_in  input  1  input qualifier; a/b/b_in are sampled every clock regardless
diff  output  size  registered difference, (a - b - b_in) mod 2^size
b_out  output  1  registered borrow-out; 1 iff a < b + b_in (unsigned)
v_out  output  1  v_in delayed by latency; qualifies diff/b_out

Behaviour:
- One clock, reset is asynchronous and active-low. Reset asserts immediately, independent of clock. While reset = 0:
  - diff = 0, b_out = 0, v_out = 0.
  - All internal stage registers, including their valid bits, = 0.
- Latency: 3 clock edges. Operands sampled at edge N appear on diff/b_out/v_out after edge N+2 (3rd edge counting the sampling edge). Throughput: 1 operation per clock, no stalls, no backpressure.
- Stage 1, input register (IR):
  - Captures a_lo, a_hi, b_lo, b_hi, b_in, v_in unconditionally each edge.
- Stage 2, pipeline register (PR):
  - Computes {brw_mid, d_lo} = {1'b0,a_lo} - {1'b0,b_lo} - b_in, using half+1 bit arithmetic. Bit [half] is the borrow, 1 when a_lo < b_lo + b_in.
  - Forwards a_hi, b_hi and the valid bit unchanged.
- Stage 3, output register (OR):
  - Computes {b_out, d_hi} = {1'b0,a_hi} - {1'b0,b_hi} - brw_mid.
  - Registers diff = {d_hi, d_lo} and v_out.
- Width rules: all arithmetic is unsigned and zero-extended to half+1 bits. No sign interpretation; two's-complement users take diff as-is and ignore b_out.
- Wrap-around: 0 - 1 gives diff = all ones, b_out = 1. a = b with b_in = 1 also gives all ones, b_out = 1.
- Data stages advance every clock even when v_in = 0. Invalid slots carry don't-care data, but v_out must be 0 for them.
- Reset mid-operation: all in-flight results are discarded, and v_out stays 0 until the first valid operand after reset release has travelled the full 3 stages.
- No combinational path from any input to any output.

Decomposition:
- Shared header (Chapter 9 arithmetic defines): width constants SIZE = 16 and HALF = SIZE/2. The pipelined adder and subtractor both use it.
- One natural sub-module: half_sub, combinational, parameterized width w.
  - Ports: x, y, bi -> d, bo.
  - Instantiated twice: low slice feeding PR, high slice feeding OR.
  - All registers stay in sub_16_pipe.

Test Plan:
- reset = 0 with random a/b/v_in toggling -> diff = 0x0000, b_out = 0, v_out = 0 throughout. Release reset between edges -> outputs stay 0 until a valid op has had 3 edges.
- a = 0x1234, b = 0x0234, b_in = 0, v_in = 1 -> after 3 edges: diff = 0x1000, b_out = 0, v_out = 1 for exactly one cycle.
- a = 0x0100, b = 0x0001, b_in = 0 (borrow crosses the half boundary) -> diff = 0x00FF, b_out = 0. Also a = 0x0000, b = 0x0001 -> diff = 0xFFFF, b_out = 1.
- a = 0x8000, b = 0x8000, b_in = 1 -> diff = 0xFFFF, b_out = 1. Same operands with b_in = 0 -> diff = 0x0000, b_out = 0.
- Back-to-back stream of 20 random valid ops with v_in holes every 4th cycle -> each output matches the reference model exactly 3 edges later; v_out mirrors the hole pattern.
- Assert reset asynchronously mid-clock while 3 valid ops are in flight -> v_out, diff and b_out drop to 0 at once, without waiting for an edge. The in-flight ops never appear after release.
